// File: rtl/cr_huf_comp_lut_bank_rcv.sv
// Two-bank ping-pong code-table store between the symbol table builder and the encoder.
// Latency: reads return 1 cycle after lut_rd_req; a table is visible 1 cycle after wr_done.
// Backpressure: lut_st_full (registered occ==2) stalls the builder; writes made while full are dropped.
// Optional even-parity protection of RAM entries: define CR_HUF_COMP_LUT_RCV_PARITY_EN.
module cr_huf_comp_lut_bank_rcv #(
    parameter int DAT_WIDTH  = 24,
    parameter int DEPTH      = 584,
    parameter int ADDR_W     = 10,
    parameter int STCL_DEPTH = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_lut_wr,
    input  logic                 st_lut_wr_type,
    input  logic [DAT_WIDTH-1:0] st_lut_wr_data,
    input  logic [ADDR_W-1:0]    st_lut_wr_addr,
    input  logic                 st_lut_wr_done,
    input  logic                 st_lut_sizes_val,
    input  logic [3:0]           st_lut_seq_id,
    input  logic [15:0]          st_lut_st_size,
    input  logic [7:0]           st_lut_stcl_size,
    input  logic [3:0]           st_lut_hclen,
    input  logic [4:0]           st_lut_hlit,
    input  logic [4:0]           st_lut_hdist,
    output logic                 lut_st_full,
    output logic                 lut_tbl_rdy,
    output logic [3:0]           lut_tbl_seq_id,
    output logic [15:0]          lut_tbl_st_size,
    output logic [7:0]           lut_tbl_stcl_size,
    output logic [3:0]           lut_tbl_hclen,
    output logic [4:0]           lut_tbl_hlit,
    output logic [4:0]           lut_tbl_hdist,
    input  logic                 lut_rd_req,
    input  logic                 lut_rd_type,
    input  logic [ADDR_W-1:0]    lut_rd_addr,
    output logic                 lut_rd_vld,
    output logic [DAT_WIDTH-1:0] lut_rd_data,
    input  logic                 lut_rd_done,
    output logic                 lut_wr_err,
    output logic                 lut_rd_par_err
);

    localparam int SYM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STCL_AW = (STCL_DEPTH > 1) ? $clog2(STCL_DEPTH) : 1;
`ifdef CR_HUF_COMP_LUT_RCV_PARITY_EN
    localparam int RAM_W = DAT_WIDTH + 1;
`else
    localparam int RAM_W = DAT_WIDTH;
`endif

    typedef enum logic [1:0] {EMPTY, FILLING, READY} bank_st_t;

    typedef struct packed {
        logic [3:0]  seq_id;
        logic [15:0] st_size;
        logic [7:0]  stcl_size;
        logic [3:0]  hclen;
        logic [4:0]  hlit;
        logic [4:0]  hdist;
    } meta_t;

    bank_st_t [1:0] st, st_nxt;
    logic           wbank, wbank_nxt, rbank, rbank_nxt;
    logic [1:0]     occ, occ_nxt;
    meta_t          meta [2];
    meta_t          rd_meta;

    logic [RAM_W-1:0] sym_ram  [2][DEPTH];
    logic [RAM_W-1:0] stcl_ram [2][STCL_DEPTH];
    logic [RAM_W-1:0] wr_word;

    logic wr_full, wr_in_rng, rd_in_rng;
    logic wr_ok, done_ok, rd_ok, rd_done_ok, wr_err_nxt;

    // Full decision uses registered occ, so a same-cycle rd_done does not admit a write.
    assign wr_full    = (occ == 2'd2);
    assign wr_in_rng  = st_lut_wr_type ? ({1'b0, st_lut_wr_addr} < (ADDR_W+1)'(STCL_DEPTH))
                                       : ({1'b0, st_lut_wr_addr} < (ADDR_W+1)'(DEPTH));
    assign rd_in_rng  = lut_rd_type ? ({1'b0, lut_rd_addr} < (ADDR_W+1)'(STCL_DEPTH))
                                    : ({1'b0, lut_rd_addr} < (ADDR_W+1)'(DEPTH));
    assign wr_ok      = st_lut_wr && !wr_full && wr_in_rng;
    assign done_ok    = st_lut_wr_done && !wr_full;
    assign wr_err_nxt = (st_lut_wr && !wr_ok) || (st_lut_wr_done && wr_full);
    assign rd_ok      = lut_rd_req && lut_tbl_rdy;
    assign rd_done_ok = lut_rd_done && lut_tbl_rdy;

    assign lut_st_full = wr_full;
    assign lut_tbl_rdy = (st[rbank] == READY);

    assign rd_meta           = lut_tbl_rdy ? meta[rbank] : '0;
    assign lut_tbl_seq_id    = rd_meta.seq_id;
    assign lut_tbl_st_size   = rd_meta.st_size;
    assign lut_tbl_stcl_size = rd_meta.stcl_size;
    assign lut_tbl_hclen     = rd_meta.hclen;
    assign lut_tbl_hlit      = rd_meta.hlit;
    assign lut_tbl_hdist     = rd_meta.hdist;

`ifdef CR_HUF_COMP_LUT_RCV_PARITY_EN
    assign wr_word = {^st_lut_wr_data, st_lut_wr_data};
`else
    assign wr_word = st_lut_wr_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= {EMPTY, EMPTY};
            wbank <= 1'b0;
            rbank <= 1'b0;
            occ   <= 2'd0;
        end else begin
            st    <= st_nxt;
            wbank <= wbank_nxt;
            rbank <= rbank_nxt;
            occ   <= occ_nxt;
        end
    end

    // An accepted wr_done implies occ<2, so wbank and rbank differ whenever both close/release.
    always_comb begin
        st_nxt    = st;
        wbank_nxt = wbank;
        rbank_nxt = rbank;
        occ_nxt   = occ;
        if (wr_ok && st[wbank] == EMPTY)
            st_nxt[wbank] = FILLING;
        if (done_ok) begin
            st_nxt[wbank] = READY;
            wbank_nxt     = ~wbank;
        end
        if (rd_done_ok) begin
            st_nxt[rbank] = EMPTY;
            rbank_nxt     = ~rbank;
        end
        case ({done_ok, rd_done_ok})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta[0] <= '0;
            meta[1] <= '0;
        end else if (st_lut_sizes_val && !wr_full) begin
            meta[wbank] <= '{st_lut_seq_id, st_lut_st_size, st_lut_stcl_size,
                             st_lut_hclen, st_lut_hlit, st_lut_hdist};
        end
    end

    // Table RAMs carry no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (st_lut_wr_type)
                stcl_ram[wbank][st_lut_wr_addr[STCL_AW-1:0]] <= wr_word;
            else
                sym_ram[wbank][st_lut_wr_addr[SYM_AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lut_rd_vld     <= 1'b0;
            lut_rd_data    <= '0;
            lut_rd_par_err <= 1'b0;
            lut_wr_err     <= 1'b0;
        end else begin
            lut_wr_err     <= wr_err_nxt;
            lut_rd_vld     <= rd_ok;
            lut_rd_par_err <= 1'b0;
            if (rd_ok) begin
                if (!rd_in_rng) begin
                    lut_rd_data <= '0;
                end else if (lut_rd_type) begin
                    lut_rd_data <= stcl_ram[rbank][lut_rd_addr[STCL_AW-1:0]][DAT_WIDTH-1:0];
`ifdef CR_HUF_COMP_LUT_RCV_PARITY_EN
                    lut_rd_par_err <= ^stcl_ram[rbank][lut_rd_addr[STCL_AW-1:0]];
`endif
                end else begin
                    lut_rd_data <= sym_ram[rbank][lut_rd_addr[SYM_AW-1:0]][DAT_WIDTH-1:0];
`ifdef CR_HUF_COMP_LUT_RCV_PARITY_EN
                    lut_rd_par_err <= ^sym_ram[rbank][lut_rd_addr[SYM_AW-1:0]];
`endif
                end
            end
        end
    end

endmodule
